fifo_word_serializer: RTL

Downstream consumer of the 384-bit single-entry FIFO stage. Dequeues one 384-bit element via the FIFO's `first`/`deq` methods, holds it in a shift register, and emits it as twelve 32-bit words through an `enq`-style handshake to the next narrow stage. Back-to-back elements stream with no bubble between the last word of one element and the first word of the next.

---
 rtl/fifo_ser_pkg.sv | 18 +
 rtl/fifo_ser_beat_ctr.sv | 28 ++
 rtl/fifo_word_serializer.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the 384-bit to 32-bit word serializer.
package fifo_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int DFLT_DATA_WIDTH = 384;
    localparam int DFLT_WORD_WIDTH = 32;
    localparam int DFLT_BEATS      = DFLT_DATA_WIDTH / DFLT_WORD_WIDTH;
    localparam int DFLT_BEAT_W     = $clog2(DFLT_BEATS);

    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fifo_ser_beat_ctr.sv
// Beat index of the word currently offered downstream; wraps to zero after the
// terminal beat and flags that beat on `last`.
module fifo_ser_beat_ctr #(
    parameter int BEATS  = 12,
    parameter int BEAT_W = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic load,
    input  logic inc,
    output logic last
);

    localparam logic [BEAT_W-1:0] TERM = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0] beat;

    assign last = (beat == TERM);

    always_ff @(posedge CLK) begin
        if (!nRST || load) begin
            beat <= '0;
        end else if (inc) begin
            beat <= last ? '0 : beat + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pulls one wide element from the upstream FIFO and streams it out as words.
// Define SER_MSB_FIRST_EN to emit the most significant word first.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int WORD_WIDTH = DFLT_WORD_WIDTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [DATA_WIDTH-1:0] in_first,
  input  logic                  in_first__RDY,
  input  logic                  in_deq__RDY,
  output logic                  in_deq__ENA,
  input  logic                  out_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [WORD_WIDTH-1:0] out_enq_v,
  output logic                  busy
);

  localparam int NUM_BEATS = DATA_WIDTH / WORD_WIDTH;
  localparam int CNT_W     = beat_width(NUM_BEATS);

  generate
    if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_width_check
      $error("fifo_word_serializer: DATA_WIDTH must be a multiple of WORD_WIDTH");
    end
  endgenerate

  ser_state_t            state, state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  xfer, cap, last;

  fifo_ser_beat_ctr #(
    .BEATS  (NUM_BEATS),
    .BEAT_W (CNT_W)
  ) u_beat_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .load (cap),
    .inc  (xfer),
    .last (last)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new element may be taken in the same cycle the final word leaves,
  // which is what keeps consecutive elements bubble-free.
  always_comb begin
    state_next = state;
    xfer       = (state == SEND) && out_enq__RDY;
    cap        = nRST && in_first__RDY && in_deq__RDY
                 && ((state == IDLE) || (xfer && last));
    if (cap) begin
      state_next = SEND;
    end else if (xfer && last) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      shreg <= '0;
    end else if (cap) begin
      shreg <= in_first;
    end else if (xfer && !last) begin
`ifdef SER_MSB_FIRST_EN
      shreg <= shreg << WORD_WIDTH;
`else
      shreg <= shreg >> WORD_WIDTH;
`endif
    end
  end

`ifdef SER_MSB_FIRST_EN
  assign out_enq_v = shreg[DATA_WIDTH-1 -: WORD_WIDTH];
`else
  assign out_enq_v = shreg[WORD_WIDTH-1:0];
`endif

  assign out_enq__ENA = xfer;
  assign in_deq__ENA  = cap;
  assign busy         = (state == SEND);

endmodule
